debounce_scanner: RTL and testbench
===================================

Name: debounce_scanner

Overview:
- Shared debounce controller for N_BTN front-panel buttons.
- Owns the sample-tick prescaler and scans every channel's history once per tick, one channel per clk cycle.
- Maintains per-channel debounced levels and pushes press/release events into a small FIFO with a valid/ready handshake.
- Replaces per-button debouncers, each with its own slow clock, by one time-multiplexed sequencer in the clk domain.

Parameters:
- N_BTN, 4: number of button channels (2..16).
- HIST_LEN, 8: samples per channel history; all-ones or all-zeros is required to change state.
- DIV_W, 16: prescaler width.
- DIV_DEFAULT, 50000: prescaler reload after reset. Tick period is DIV_DEFAULT+1 clk cycles.
- EVT_DEPTH, 4: event FIFO depth (power of 2).
- LONG_TICKS, 200: long-press threshold in ticks. Used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- buttons  in  N_BTN  raw asynchronous button inputs.
- div_load  in  1  one-cycle strobe; load div_value into the prescaler reload register.
- div_value  in  DIV_W  new reload value.
- debounced  out  N_BTN  debounced level per channel.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_chan  out  clog2(N_BTN)  channel of the head event.
- evt_kind  out  2  head event type: 01 = press, 00 = release, 10 = long-press.
- overflow  out  1  sticky; an event was dropped.
- clear_ovf  in  1  clears overflow.

Behaviour:
- Reset (reset_n low at a clk edge) forces the following; applies mid-scan too, with no partial event left:
  - all histories 0, debounced 0, FIFO empty, evt_valid 0, overflow 0.
  - prescaler count and reload = DIV_DEFAULT; FSM = IDLE.
- Input synchroniser: each buttons bit passes through a 2-flop synchroniser, reset to 0. Only synchronised values are sampled.
- Prescaler:
  - Down-counter. At 0 it asserts tick for one cycle and reloads.
  - div_load writes reload = max(div_value, N_BTN) and restarts the count from the new value on the next cycle. The clamp guarantees a scan always finishes before the next tick.
- FSM:
  - IDLE: on tick, idx <= 0, go to SCAN.
  - SCAN: each cycle, for channel idx:
    - hist[idx] <= {hist[idx][HIST_LEN-2:0], sync[idx]}.
    - The decision uses the updated history value.
    - updated all-ones and debounced[idx]=0: debounced[idx] <= 1, push press.
    - updated all-zeros and debounced[idx]=1: debounced[idx] <= 0, push release.
    - otherwise hold.
    - idx increments; after idx = N_BTN-1, go to IDLE. A scan takes exactly N_BTN cycles.
- debounced[idx] changes on the clk edge that ends that channel's scan cycle.
  - The event is visible on evt_* the following cycle if the FIFO was empty (latency 1).
- FIFO:
  - Pop when evt_valid and evt_ready.
  - Push when full with no simultaneous pop: event dropped, overflow <= 1, debounced still updates.
  - Push and pop in the same cycle when full: both accepted.
  - Head outputs are stable while evt_valid and not evt_ready.
  - Events are ordered by scan order, channel 0 first within a tick.
- overflow: clear_ovf clears it. If clear_ovf and a new drop occur in the same cycle, overflow stays 1.

Optional Feature:
LONG_PRESS_EN
- Defined:
  - Each channel has a hold counter, reset on its release event and on reset.
  - The counter increments on that channel's scan cycle while debounced=1, saturating at LONG_TICKS.
  - When the counter reaches exactly LONG_TICKS, push one long-press event (kind 10). It fires once per press, in addition to press and release.
- Not defined: no counters are instantiated; evt_kind[1] is constant 0.

Test Plan:
- Reset with all buttons high, then hold for 8 ticks, DIV_DEFAULT=9 -> debounced[0..3] rise in channel order during the scan of the 8th full-ones tick; 4 press events with chan 0,1,2,3.
- Channel 2 toggles every tick for 20 ticks -> debounced[2] stays 0; no events; overflow 0.
- Press channel 1 for 10 ticks, then release for 10 ticks, evt_ready=1 -> exactly press(chan 1) then release(chan 1); evt_valid is high one cycle after each debounced edge.
- evt_ready=0; generate 6 events (EVT_DEPTH=4) -> 4 retained, overflow=1, head stable; then clear_ovf with evt_ready=1 -> overflow 0, 4 events drain in order.
- div_load with div_value=1, N_BTN=4 -> tick period 5 cycles (clamped); scans never overlap; reset_n low mid-scan -> all outputs 0 the next cycle.
- LONG_PRESS_EN, LONG_TICKS=3: hold channel 0 -> press, then exactly one long-press (kind 10) 3 ticks after the press; release -> release event; second hold restarts the count.

Source files
------------

// File: rtl/debounce_scanner.sv
// debounce_scanner: time-multiplexed N_BTN debouncer with prescaler, scan FSM and event FIFO; define LONG_PRESS_EN for long-press events
module debounce_scanner #(
  parameter int N_BTN       = 4,
  parameter int HIST_LEN    = 8,
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 50000,
  parameter int EVT_DEPTH   = 4,
  parameter int LONG_TICKS  = 200
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_BTN-1:0]         buttons,
  input  logic                     div_load,
  input  logic [DIV_W-1:0]         div_value,
  output logic [N_BTN-1:0]         debounced,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_chan,
  output logic [1:0]               evt_kind,
  output logic                     overflow,
  input  logic                     clear_ovf
);
  localparam int IW = $clog2(N_BTN);
  localparam int AW = $clog2(EVT_DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  logic [N_BTN-1:0] sync1, sync2;
  logic [DIV_W-1:0] cnt, reload, clamp;
  logic [0:0] state;
  logic [IW-1:0] idx;
  logic [HIST_LEN-1:0] hist [N_BTN];
  logic [HIST_LEN-1:0] new_h;
  logic tick, rise, fall, long_fire, push, pop, full, acc, drop;
  logic [1:0] push_kind;
  logic [IW-1:0] mem_chan [EVT_DEPTH];
  logic [1:0] mem_kind [EVT_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] fill;
  assign clamp = div_value < DIV_W'(N_BTN) ? DIV_W'(N_BTN) : div_value;
  assign tick = cnt == '0;
  assign full = fill == (AW+1)'(EVT_DEPTH);
  assign evt_valid = fill != '0;
  assign pop = evt_valid && evt_ready;
  assign acc = push && (!full || pop);
  assign drop = push && full && !pop;
  assign evt_chan = evt_valid ? mem_chan[rp] : '0;
  assign evt_kind = evt_valid ? mem_kind[rp] : '0;
  always_comb begin
    new_h = {hist[idx][HIST_LEN-2:0], sync2[idx]};
    rise = state == SCAN && (&new_h) && !debounced[idx];
    fall = state == SCAN && !(|new_h) && debounced[idx];
    push = rise || fall || long_fire;
    push_kind = {long_fire, rise};
  end
`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  logic [HW-1:0] hold [N_BTN];
  assign long_fire = state == SCAN && debounced[idx] && !fall && hold[idx] == HW'(LONG_TICKS - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) for (int i = 0; i < N_BTN; i++) hold[i] <= '0;
    else if (state == SCAN)
      hold[idx] <= fall ? '0 : (debounced[idx] && hold[idx] != HW'(LONG_TICKS)) ? hold[idx] + 1'b1 : hold[idx];
  end
`else
  assign long_fire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt <= DIV_W'(DIV_DEFAULT);
      reload <= DIV_W'(DIV_DEFAULT);
      state <= IDLE;
      idx <= '0;
      debounced <= '0;
      overflow <= 1'b0;
      wp <= '0;
      rp <= '0;
      fill <= '0;
      for (int i = 0; i < N_BTN; i++) hist[i] <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      reload <= div_load ? clamp : reload;
      cnt <= div_load ? clamp : tick ? reload : cnt - 1'b1;
      if (state == IDLE) begin
        state <= tick ? SCAN : IDLE;
        idx <= '0;
      end else begin
        hist[idx] <= new_h;
        debounced[idx] <= rise ? 1'b1 : fall ? 1'b0 : debounced[idx];
        idx <= idx + 1'b1;
        state <= idx == IW'(N_BTN - 1) ? IDLE : SCAN;
      end
      wp <= acc ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      fill <= fill + (AW+1)'(acc) - (AW+1)'(pop);
      overflow <= drop || (overflow && !clear_ovf);
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      mem_chan[wp] <= idx;
      mem_kind[wp] <= push_kind;
    end
  end
endmodule

// File: tb/tb_debounce_scanner.sv
// tb_debounce_scanner: directed self-checking bench for debounce_scanner
module tb_debounce_scanner;
`ifdef LONG_PRESS_EN
  localparam logic LP = 1'b1;
`else
  localparam logic LP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic div_load = 1'b0;
  logic evt_ready = 1'b1;
  logic clear_ovf = 1'b0;
  logic evt_valid, overflow;
  logic [3:0] buttons = 4'b0;
  logic [3:0] debounced;
  logic [15:0] div_value = 16'd0;
  logic [1:0] evt_chan, evt_kind;
  int total = 0;
  int bad = 0;
  debounce_scanner #(
    .N_BTN(4), .HIST_LEN(8), .DIV_W(16), .DIV_DEFAULT(9), .EVT_DEPTH(4), .LONG_TICKS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons), .div_load(div_load), .div_value(div_value),
    .debounced(debounced), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
    .evt_kind(evt_kind), .overflow(overflow), .clear_ovf(clear_ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic [3:0] b);
    reset_n = 1'b0;
    buttons = b;
    div_load = 1'b0;
    clear_ovf = 1'b0;
    evt_ready = 1'b1;
    step(3);
    reset_n = 1'b1;
  endtask
  initial begin
    do_reset(4'b1111);
    check("rst deb", debounced, 0);
    check("rst valid", evt_valid, 0);
    check("rst ovf", overflow, 0);
    step(80);
    check("t1 deb before", debounced, 4'b0000);
    step(1);
    check("t1 deb0", debounced, 4'b0001);
    check("t1 ev0", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd0, 2'b01});
    step(1);
    check("t1 deb1", debounced, 4'b0011);
    check("t1 ev1", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd1, 2'b01});
    step(1);
    check("t1 ev2", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd2, 2'b01});
    step(1);
    check("t1 deb3", debounced, 4'b1111);
    check("t1 ev3", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd3, 2'b01});
    step(1);
    check("t1 empty", evt_valid, 0);
    do_reset(4'b0000);
    for (int j = 0; j < 20; j++) begin
      buttons[2] = ~buttons[2];
      step(10);
      check("t2 deb", debounced, 0);
      check("t2 valid", evt_valid, 0);
    end
    check("t2 ovf", overflow, 0);
    do_reset(4'b0000);
    buttons = 4'b0010;
    step(81);
    check("t3 pre deb", debounced, 0);
    check("t3 pre valid", evt_valid, 0);
    step(1);
    check("t3 press deb", debounced, 4'b0010);
    check("t3 press ev", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd1, 2'b01});
    step(1);
    check("t3 press gone", evt_valid, 0);
    step(17);
    buttons = 4'b0000;
    step(81);
    check("t3 held deb", debounced, 4'b0010);
    check("t3 held valid", evt_valid, 0);
    step(1);
    check("t3 rel deb", debounced, 0);
    check("t3 rel ev", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd1, 2'b00});
    step(1);
    check("t3 rel gone", evt_valid, 0);
    do_reset(4'b1111);
    evt_ready = 1'b0;
    step(85);
    buttons = 4'b1100;
    step(15);
    check("t4 head", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd0, 2'b01});
    check("t4 ovf0", overflow, 0);
    step(62);
    check("t4 ovf1", overflow, 1);
    check("t4 deb", debounced, 4'b1100);
    check("t4 head stable", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd0, 2'b01});
    clear_ovf = 1'b1;
    evt_ready = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    check("t4 ovf clr", overflow, 0);
    check("t4 drain1", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd1, 2'b01});
    step(1);
    check("t4 drain2", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd2, 2'b01});
    step(1);
    check("t4 drain3", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd3, 2'b01});
    step(1);
    check("t4 drained", evt_valid, 0);
    do_reset(4'b0001);
    evt_ready = 1'b0;
    div_load = 1'b1;
    div_value = 16'd1;
    step(1);
    div_load = 1'b0;
    step(40);
    check("t5 pre deb", debounced, 0);
    step(1);
    check("t5 deb", debounced, 4'b0001);
    check("t5 ev", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd0, 2'b01});
    reset_n = 1'b0;
    step(1);
    check("t5 rst outs", {debounced, evt_valid, evt_chan, evt_kind, overflow}, 0);
    do_reset(4'b0001);
    step(81);
    check("t6 press", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd0, 2'b01});
    step(29);
    check("t6 quiet", evt_valid, 0);
    step(1);
    check("t6 long", {evt_valid, evt_chan, evt_kind}, {LP, 2'd0, LP, 1'b0});
    step(1);
    check("t6 long gone", evt_valid, 0);
    buttons = 4'b0000;
    step(79);
    check("t6 rel", {debounced, evt_valid, evt_chan, evt_kind}, {4'b0000, 1'b1, 2'd0, 2'b00});
    step(1);
    buttons = 4'b0001;
    step(79);
    check("t6 press2", {evt_valid, evt_chan, evt_kind}, {1'b1, 2'd0, 2'b01});
    step(29);
    check("t6 quiet2", evt_valid, 0);
    step(1);
    check("t6 long2", {evt_valid, evt_chan, evt_kind}, {LP, 2'd0, LP, 1'b0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
